// File: rtl/axi_ram_reader.sv
// AXI4 read-only slave that serves INCR/FIFO-buffered bursts from a RAM with 1-cycle read latency.
// Define AXI_RAM_READER_ERR_CHECK_EN to enable SLVERR/DECERR checking of AR requests.
module axi_ram_reader #(
  parameter int AXI_DATA_W = 128,
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_ar_arvalid,
  output logic                  axi_ar_arready,
  input  logic [AXI_ID_W-1:0]   axi_ar_arid,
  input  logic [AXI_ADDR_W-1:0] axi_ar_araddr,
  input  logic [3:0]            axi_ar_arregion,
  input  logic [7:0]            axi_ar_arlen,
  input  logic [2:0]            axi_ar_arsize,
  input  logic [1:0]            axi_ar_arburst,
  input  logic [3:0]            axi_ar_arcache,
  input  logic [2:0]            axi_ar_arprot,
  input  logic [3:0]            axi_ar_arqos,
  output logic                  axi_r_rvalid,
  input  logic                  axi_r_rready,
  output logic [AXI_ID_W-1:0]   axi_r_rid,
  output logic [AXI_DATA_W-1:0] axi_r_rdata,
  output logic [1:0]            axi_r_rresp,
  output logic                  axi_r_rlast,
  output logic                  mem_rd_en,
  output logic [MEM_ADDR_W-1:0] mem_rd_addr,
  input  logic [AXI_DATA_W-1:0] mem_rd_data
);

  localparam int BYTES = AXI_DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam logic [1:0] RESP_OKAY = 2'd0;
`ifdef AXI_RAM_READER_ERR_CHECK_EN
  localparam int HI_LSB = MEM_ADDR_W + OFF_W;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state, state_next;
  logic                    arready_en;
  logic [AXI_ID_W-1:0]     burst_id;
  logic [AXI_ADDR_W-1:0]   burst_addr;
  logic [7:0]              burst_len;
  logic [7:0]              beat_cnt;
  logic                    burst_fixed;
  logic [1:0]              burst_resp;

  logic [1:0]              ar_resp;
  logic                    ar_fixed;
  logic                    ar_hs;
  logic                    issue;
  logic                    last_issue;
  logic                    pop;
  logic                    push;
  logic [2:0]              occ_after_pop;
  logic [AXI_ADDR_W-1:0]   word_addr;

  logic                    pend_valid;
  logic [AXI_ID_W-1:0]     pend_id;
  logic [1:0]              pend_resp;
  logic                    pend_last;

  logic [AXI_ID_W-1:0]     fifo_id   [0:1];
  logic [AXI_DATA_W-1:0]   fifo_data [0:1];
  logic [1:0]              fifo_resp [0:1];
  logic                    fifo_last [0:1];
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              fifo_count;

  logic                    unused_ok;

  // Response code is decided once per burst from the AR fields and then reused for every beat.
  always_comb begin
    ar_resp  = RESP_OKAY;
    ar_fixed = (axi_ar_arburst == 2'b00);
`ifdef AXI_RAM_READER_ERR_CHECK_EN
    if ((axi_ar_arsize != 3'(OFF_W)) || axi_ar_arburst[1]) begin
      ar_resp = RESP_SLVERR;
    end else if ((axi_ar_araddr >> HI_LSB) != '0) begin
      ar_resp = RESP_DECERR;
    end
`endif
  end

  assign axi_ar_arready = (state == IDLE) && arready_en;
  assign ar_hs          = axi_ar_arvalid && axi_ar_arready;

  assign pop  = axi_r_rvalid && axi_r_rready;
  assign push = pend_valid;

  // Counting the beat leaving this cycle lets a full-rate stream keep issuing without FIFO overflow.
  assign occ_after_pop = 3'(fifo_count) + 3'(pend_valid) - 3'(pop);
  assign issue         = (state == BURST) && (occ_after_pop < 3'd2);
  assign last_issue    = issue && (beat_cnt == burst_len);

  assign word_addr   = burst_addr >> OFF_W;
  assign mem_rd_en   = issue && (burst_resp == RESP_OKAY);
  assign mem_rd_addr = mem_rd_en ? MEM_ADDR_W'(word_addr) : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ar_hs)      state_next = BURST;
      BURST:   if (last_issue) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      arready_en <= 1'b0;
    end else begin
      state      <= state_next;
      arready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_id    <= '0;
      burst_addr  <= '0;
      burst_len   <= '0;
      beat_cnt    <= '0;
      burst_fixed <= 1'b0;
      burst_resp  <= RESP_OKAY;
    end else if (ar_hs) begin
      burst_id    <= axi_ar_arid;
      burst_addr  <= axi_ar_araddr;
      burst_len   <= axi_ar_arlen;
      beat_cnt    <= '0;
      burst_fixed <= ar_fixed;
      burst_resp  <= ar_resp;
    end else if (issue) begin
      beat_cnt <= beat_cnt + 8'd1;
      if (!burst_fixed) begin
        burst_addr <= burst_addr + AXI_ADDR_W'(BYTES);
      end
    end
  end

  // One-cycle stage that lines beat metadata up with the RAM read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_id    <= '0;
      pend_resp  <= RESP_OKAY;
      pend_last  <= 1'b0;
    end else begin
      pend_valid <= issue;
      if (issue) begin
        pend_id   <= burst_id;
        pend_resp <= burst_resp;
        pend_last <= (beat_cnt == burst_len);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_id[i]   <= '0;
        fifo_data[i] <= '0;
        fifo_resp[i] <= RESP_OKAY;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_id[wr_ptr]   <= pend_id;
        fifo_data[wr_ptr] <= (pend_resp == RESP_OKAY) ? mem_rd_data : '0;
        fifo_resp[wr_ptr] <= pend_resp;
        fifo_last[wr_ptr] <= pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign axi_r_rvalid = (fifo_count != 2'd0);
  assign axi_r_rid    = fifo_id[rd_ptr];
  assign axi_r_rdata  = fifo_data[rd_ptr];
  assign axi_r_rresp  = fifo_resp[rd_ptr];
  assign axi_r_rlast  = fifo_last[rd_ptr];

  assign unused_ok = ^{axi_ar_arregion, axi_ar_arcache, axi_ar_arprot, axi_ar_arqos,
                       axi_ar_arsize, word_addr};

endmodule

// File: tb/tb_axi_ram_reader.sv
// Randomized self-checking bench for axi_ram_reader with a per-burst reference model.
// Expectations follow AXI_RAM_READER_ERR_CHECK_EN when it is defined for the build.
module tb_axi_ram_reader;

  localparam int DW = 128;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int MW = 8;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          axi_ar_arvalid = 1'b0;
  logic          axi_ar_arready;
  logic [IW-1:0] axi_ar_arid = '0;
  logic [AW-1:0] axi_ar_araddr = '0;
  logic [3:0]    axi_ar_arregion = '0;
  logic [7:0]    axi_ar_arlen = '0;
  logic [2:0]    axi_ar_arsize = '0;
  logic [1:0]    axi_ar_arburst = '0;
  logic [3:0]    axi_ar_arcache = '0;
  logic [2:0]    axi_ar_arprot = '0;
  logic [3:0]    axi_ar_arqos = '0;
  logic          axi_r_rvalid;
  logic          axi_r_rready = 1'b0;
  logic [IW-1:0] axi_r_rid;
  logic [DW-1:0] axi_r_rdata;
  logic [1:0]    axi_r_rresp;
  logic          axi_r_rlast;
  logic          mem_rd_en;
  logic [MW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;

  logic [DW-1:0] ram [0:255];
  beat_t         exp_q[$];
  beat_t         obs_q[$];
  logic [MW-1:0] rd_addr_q[$];
  int            rd_cyc_q[$];
  int            cyc = 0;
  int            issued = 0;
  int            accepted = 0;
  int            peak_occ = 0;
  int            tests = 0;
  int            fails = 0;

  axi_ram_reader #(
    .AXI_DATA_W(DW), .AXI_ADDR_W(AW), .AXI_ID_W(IW), .MEM_ADDR_W(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .axi_ar_arvalid(axi_ar_arvalid), .axi_ar_arready(axi_ar_arready),
    .axi_ar_arid(axi_ar_arid), .axi_ar_araddr(axi_ar_araddr),
    .axi_ar_arregion(axi_ar_arregion), .axi_ar_arlen(axi_ar_arlen),
    .axi_ar_arsize(axi_ar_arsize), .axi_ar_arburst(axi_ar_arburst),
    .axi_ar_arcache(axi_ar_arcache), .axi_ar_arprot(axi_ar_arprot),
    .axi_ar_arqos(axi_ar_arqos),
    .axi_r_rvalid(axi_r_rvalid), .axi_r_rready(axi_r_rready),
    .axi_r_rid(axi_r_rid), .axi_r_rdata(axi_r_rdata),
    .axi_r_rresp(axi_r_rresp), .axi_r_rlast(axi_r_rlast),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, garbage on idle cycles so error beats must zero their data.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    else           mem_rd_data <= {$urandom, $urandom, $urandom, $urandom};
  end

  // Passive monitor: records accepted beats, RAM reads and peak outstanding beats.
  always @(negedge clk) begin
    beat_t b;
    int    hs;
    int    occ;
    if (rst) begin
      hs = (axi_r_rvalid && axi_r_rready) ? 1 : 0;
      if (hs == 1) begin
        b.id = axi_r_rid; b.data = axi_r_rdata; b.resp = axi_r_rresp; b.last = axi_r_rlast;
        obs_q.push_back(b);
      end
      if (mem_rd_en) begin
        rd_addr_q.push_back(mem_rd_addr);
        rd_cyc_q.push_back(cyc);
      end
      occ = issued + (mem_rd_en ? 1 : 0) - accepted - hs;
      if (occ > peak_occ) peak_occ = occ;
      issued   = issued + (mem_rd_en ? 1 : 0);
      accepted = accepted + hs;
    end
  end

  // Reference: one burst expands to arlen+1 beats computed from the address arithmetic rules.
  function automatic void model_ar(input logic [7:0] id, input logic [15:0] addr,
                                   input logic [7:0] len, input logic [2:0] size,
                                   input logic [1:0] burst);
    logic [1:0]  resp;
    logic [15:0] a;
    beat_t       b;
    resp = 2'd0;
`ifdef AXI_RAM_READER_ERR_CHECK_EN
    if (size != 3'd4 || burst >= 2'd2) resp = 2'd2;
    else if (addr >= 16'h1000)         resp = 2'd3;
`endif
    for (int i = 0; i <= int'(len); i++) begin
      a      = (burst == 2'd0) ? addr : 16'(int'(addr) + 16 * i);
      b.id   = id;
      b.resp = resp;
      b.last = (i == int'(len));
      b.data = (resp == 2'd0) ? ram[(int'(a) / 16) % 256] : '0;
      exp_q.push_back(b);
    end
  endfunction

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
    issued = 0; accepted = 0; peak_occ = 0;
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit done;
    done = 0;
    @(posedge clk); #1;
    axi_ar_arid = id; axi_ar_araddr = addr; axi_ar_arlen = len;
    axi_ar_arsize = size; axi_ar_arburst = burst;
    axi_ar_arregion = 4'($urandom); axi_ar_arcache = 4'($urandom);
    axi_ar_arprot = 3'($urandom); axi_ar_arqos = 4'($urandom);
    axi_ar_arvalid = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (axi_ar_arready === 1'b1) done = 1;
    end
    if (done) model_ar(id, addr, len, size, burst);
    @(posedge clk); #1;
    axi_ar_arvalid = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("[TB] FAIL ar_handshake id=%0d: arready got 0, want 1 within 300 cycles", id);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (obs_q.size() < exp_q.size() && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    axi_r_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (axi_ar_arready !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_arready: got %b want 0", axi_ar_arready);
    end
    tests++;
    if (axi_r_rvalid !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_rvalid: got %b want 0", axi_r_rvalid);
    end
    tests++;
    if ({axi_r_rid, axi_r_rdata, axi_r_rresp, axi_r_rlast} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_rpayload: got id=%h data=%h resp=%0d last=%b want all 0",
               axi_r_rid, axi_r_rdata, axi_r_rresp, axi_r_rlast);
    end
    tests++;
    if ({mem_rd_en, mem_rd_addr} !== '0) begin
      fails++; $display("[TB] FAIL reset_mem: got en=%b addr=%h want 0", mem_rd_en, mem_rd_addr);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (axi_ar_arready !== 1'b0) begin
      fails++; $display("[TB] FAIL release_arready_early: got %b want 0", axi_ar_arready);
    end
    @(posedge clk); #1;
    tests++;
    if (axi_ar_arready !== 1'b1) begin
      fails++; $display("[TB] FAIL release_arready: got %b want 1", axi_ar_arready);
    end
  endtask

  task automatic test_incr_basic();
    clear_sb();
    axi_r_rready = 1'b1;
    do_ar(8'd5, 16'h0040, 8'd3, 3'd4, 2'd1);
    wait_drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("[TB] FAIL incr_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL incr_beat%0d: got id=%h resp=%0d last=%b data=%h want id=%h resp=%0d last=%b data=%h",
                 i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data,
                 exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
      end
    end
    tests++;
    if (rd_addr_q.size() != 4) begin
      fails++; $display("[TB] FAIL incr_reads: got %0d reads want 4", rd_addr_q.size());
    end
    for (int i = 0; i < rd_addr_q.size() && i < 4; i++) begin
      tests++;
      if (rd_addr_q[i] !== 8'(4 + i) || rd_cyc_q[i] != rd_cyc_q[0] + i) begin
        fails++;
        $display("[TB] FAIL incr_read%0d: got addr=%h cycle+%0d want addr=%h cycle+%0d",
                 i, rd_addr_q[i], rd_cyc_q[i] - rd_cyc_q[0], 8'(4 + i), i);
      end
    end
    tests++;
    if (peak_occ > 2) begin
      fails++; $display("[TB] FAIL incr_occupancy: got %0d want <=2", peak_occ);
    end
  endtask

  task automatic test_fixed();
    clear_sb();
    axi_r_rready = 1'b1;
    do_ar(8'($urandom), 16'h0100, 8'd2, 3'd4, 2'd0);
    wait_drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("[TB] FAIL fixed_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL fixed_beat%0d: got id=%h resp=%0d last=%b data=%h want id=%h resp=%0d last=%b data=%h",
                 i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data,
                 exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
      end
    end
    tests++;
    if (rd_addr_q.size() != 3) begin
      fails++; $display("[TB] FAIL fixed_reads: got %0d reads want 3", rd_addr_q.size());
    end
    for (int i = 0; i < rd_addr_q.size(); i++) begin
      tests++;
      if (rd_addr_q[i] !== 8'h10) begin
        fails++; $display("[TB] FAIL fixed_read%0d: got addr=%h want 10", i, rd_addr_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic          prev_v, prev_r;
    logic [138:0]  prev_p, cur_p;
    clear_sb();
    prev_v = 1'b0; prev_r = 1'b0; prev_p = '0;
    fork
      do_ar(8'h33, 16'(16 * $urandom_range(0, 200)), 8'd7, 3'd4, 2'd1);
      begin
        for (int k = 0; k < 80; k++) begin
          @(posedge clk); #1;
          axi_r_rready = (k % 3 == 0);
          @(negedge clk);
          cur_p = {axi_r_rid, axi_r_rdata, axi_r_rresp, axi_r_rlast};
          if (prev_v && !prev_r) begin
            tests++;
            if (axi_r_rvalid !== 1'b1 || cur_p !== prev_p) begin
              fails++;
              $display("[TB] FAIL stall_hold cycle %0d: got valid=%b payload=%h want valid=1 payload=%h",
                       k, axi_r_rvalid, cur_p, prev_p);
            end
          end
          prev_v = axi_r_rvalid; prev_r = axi_r_rready; prev_p = cur_p;
        end
      end
    join
    axi_r_rready = 1'b1;
    wait_drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("[TB] FAIL stall_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL stall_beat%0d: got id=%h resp=%0d last=%b data=%h want id=%h resp=%0d last=%b data=%h",
                 i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data,
                 exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
      end
    end
    tests++;
    if (peak_occ > 2) begin
      fails++; $display("[TB] FAIL stall_occupancy: got %0d want <=2", peak_occ);
    end
  endtask

  task automatic test_errors();
    clear_sb();
    axi_r_rready = 1'b1;
    do_ar(8'd3, 16'h0010, 8'd1, 3'd2, 2'd1);
    do_ar(8'd4, 16'hFFF0, 8'd1, 3'd4, 2'd1);
    wait_drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("[TB] FAIL err_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL err_beat%0d: got id=%h resp=%0d last=%b data=%h want id=%h resp=%0d last=%b data=%h",
                 i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data,
                 exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
      end
    end
`ifdef AXI_RAM_READER_ERR_CHECK_EN
    tests++;
    if (rd_addr_q.size() != 0) begin
      fails++; $display("[TB] FAIL err_reads: got %0d reads want 0", rd_addr_q.size());
    end
`else
    tests++;
    if (rd_addr_q.size() != 4 || rd_addr_q[0] !== 8'h01 || rd_addr_q[1] !== 8'h02 ||
        rd_addr_q[2] !== 8'hFF || rd_addr_q[3] !== 8'h00) begin
      fails++;
      $display("[TB] FAIL err_reads: got %0d reads first=%h want 4 reads 01,02,ff,00",
               rd_addr_q.size(), (rd_addr_q.size() > 0) ? rd_addr_q[0] : 8'h00);
    end
`endif
  endtask

  task automatic test_back_to_back();
    bit ars_done;
    clear_sb();
    ars_done = 0;
    fork
      begin
        do_ar(8'd1, 16'(16 * $urandom_range(0, 255)), 8'($urandom_range(1, 5)), 3'd4, 2'd1);
        do_ar(8'd2, 16'(16 * $urandom_range(0, 255)), 8'($urandom_range(1, 5)), 3'd4, 2'd1);
        ars_done = 1;
      end
      while (!ars_done) begin
        @(posedge clk); #1;
        axi_r_rready = 1'($urandom);
      end
    join
    axi_r_rready = 1'b1;
    wait_drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("[TB] FAIL b2b_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL b2b_beat%0d: got id=%h resp=%0d last=%b data=%h want id=%h resp=%0d last=%b data=%h",
                 i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data,
                 exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_random();
    bit ars_done;
    clear_sb();
    ars_done = 0;
    fork
      begin
        for (int n = 0; n < 16; n++) begin
          do_ar(8'($urandom),
                $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0FFF)),
                8'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd4,
                2'($urandom));
        end
        ars_done = 1;
      end
      while (!ars_done) begin
        @(posedge clk); #1;
        axi_r_rready = ($urandom_range(0, 3) != 0);
      end
    join
    axi_r_rready = 1'b1;
    wait_drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("[TB] FAIL rand_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL rand_beat%0d: got id=%h resp=%0d last=%b data=%h want id=%h resp=%0d last=%b data=%h",
                 i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data,
                 exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int k;
    clear_sb();
    axi_r_rready = 1'b1;
    do_ar(8'd9, 16'h0200, 8'd7, 3'd4, 2'd1);
    k = 0;
    while (obs_q.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (obs_q.size() < 2) begin
      fails++; $display("[TB] FAIL midrst_start: got %0d beats want >=2", obs_q.size());
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({axi_r_rvalid, mem_rd_en, axi_ar_arready} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL midrst_outputs: got rvalid=%b rd_en=%b arready=%b want 0,0,0",
               axi_r_rvalid, mem_rd_en, axi_ar_arready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (axi_ar_arready !== 1'b1) begin
      fails++; $display("[TB] FAIL midrst_arready: got %b want 1", axi_ar_arready);
    end
    clear_sb();
    repeat (12) @(negedge clk);
    tests++;
    if (obs_q.size() != 0 || rd_addr_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL midrst_stale: got %0d beats %0d reads want 0,0", obs_q.size(), rd_addr_q.size());
    end
    do_ar(8'd10, 16'h0030, 8'd1, 3'd4, 2'd1);
    wait_drain();
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("[TB] FAIL midrst_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("[TB] FAIL midrst_beat%0d: got id=%h resp=%0d last=%b data=%h want id=%h resp=%0d last=%b data=%h",
                 i, obs_q[i].id, obs_q[i].resp, obs_q[i].last, obs_q[i].data,
                 exp_q[i].id, exp_q[i].resp, exp_q[i].last, exp_q[i].data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_incr_basic();
    test_fixed();
    test_stall();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/axi_ram_reader.md
AXI_RAM_READER -- requirements
Module: axi_ram_reader

Interface
REQ-001 Parameters SHALL be, one per line:
- AXI_DATA_W, default 128: R data width; SHALL be a power of two and at least 8.
- AXI_ADDR_W, default 16: AR byte-address width.
- AXI_ID_W, default 8: ID width.
- MEM_ADDR_W, default 12: RAM word-address width, depth 2^MEM_ADDR_W words of AXI_DATA_W bits.
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- clk, in, 1: sole clock; all logic on rising edge.
- rst, in, 1: asynchronous, active-low reset.
- axi_ar_arvalid, in, 1: AR valid.
- axi_ar_arready, out, 1: AR ready.
- axi_ar_arid, in, AXI_ID_W: AR ID.
- axi_ar_araddr, in, AXI_ADDR_W: AR byte address.
- axi_ar_arregion, in, 4: ignored.
- axi_ar_arlen, in, 8: beats minus one.
- axi_ar_arsize, in, 3: log2 bytes per beat.
- axi_ar_arburst, in, 2: 0=FIXED, 1=INCR, 2=WRAP.
- axi_ar_arcache, in, 4: ignored.
- axi_ar_arprot, in, 3: ignored.
- axi_ar_arqos, in, 4: ignored.
- axi_r_rvalid, out, 1: R valid.
- axi_r_rready, in, 1: R ready.
- axi_r_rid, out, AXI_ID_W: R ID.
- axi_r_rdata, out, AXI_DATA_W: R data.
- axi_r_rresp, out, 2: 0=OKAY, 2=SLVERR, 3=DECERR.
- axi_r_rlast, out, 1: last beat of burst.
- mem_rd_en, out, 1: RAM read strobe.
- mem_rd_addr, out, MEM_ADDR_W: RAM word address.
- mem_rd_data, in, AXI_DATA_W: RAM data, valid exactly 1 cycle after mem_rd_en.

Function
REQ-003 The FSM SHALL have two states, IDLE and BURST; axi_ar_arready SHALL be 1 only in IDLE.
REQ-004 In IDLE, an AR handshake SHALL latch id, araddr, arlen, arburst and the error code, and move to BURST on the next cycle.
REQ-005 Error code: SLVERR if arsize != log2(AXI_DATA_W/8) or arburst is WRAP or 3; else DECERR if the byte-address bits above MEM_ADDR_W+log2(AXI_DATA_W/8) are non-zero; else OKAY; the code SHALL apply to every beat of the burst.
REQ-006 BURST SHALL issue exactly arlen+1 beats, one per cycle when the issue condition holds, then return to IDLE in the cycle after the last issue.
REQ-007 Issue condition: output-buffer occupancy plus beats in flight is less than 2, so that 1 beat/cycle is sustained under rready=1.
REQ-008 An OKAY beat SHALL pulse mem_rd_en with mem_rd_addr = current byte address >> log2(AXI_DATA_W/8), truncated to MEM_ADDR_W.
REQ-009 An error beat SHALL NOT assert mem_rd_en, SHALL take the same 1-cycle slot, and SHALL carry rdata = 0.
REQ-010 Beat address update: INCR adds AXI_DATA_W/8, wrapping modulo 2^AXI_ADDR_W; FIXED holds the address.
REQ-011 Each beat SHALL enter a 2-entry in-order output FIFO one cycle after issue; the R channel is the FIFO head.
REQ-012 rlast SHALL be 1 exactly on beat arlen of each burst, including arlen=0.
REQ-013 The R channel SHALL hold rvalid and all payload stable until rready; it SHALL NOT depend combinationally on rready.
REQ-014 A new AR MAY be accepted while beats of the previous burst remain in the FIFO; bursts SHALL NOT interleave.

Reset
REQ-015 Reset asserted SHALL force IDLE and an empty FIFO, cancel any in-flight read, and drive axi_ar_arready=0, axi_r_rvalid=0, axi_r_rlast=0, axi_r_rresp=0, axi_r_rid=0, axi_r_rdata=0, mem_rd_en=0 and mem_rd_addr=0.
REQ-016 axi_ar_arready SHALL rise on the first clock edge after reset deasserts; a burst interrupted by reset SHALL be discarded with no further beats.

Configuration
REQ-017 With macro AXI_RAM_READER_ERR_CHECK_EN defined, REQ-005 SHALL apply.
REQ-018 Without AXI_RAM_READER_ERR_CHECK_EN, every beat SHALL be OKAY and SHALL read RAM; the address SHALL wrap modulo the RAM size; WRAP and reserved burst types SHALL be treated as INCR.

Verification
REQ-019 The bench SHALL cover:
- AR(id=5, addr=0x0040, len=3, INCR, size=4) with rready=1 -> mem_rd_addr 4,5,6,7 on consecutive cycles; 4 beats, rid=5, OKAY, rlast on beat 3 only.
- AR(addr=0x0100, len=2, FIXED) -> three beats, all with mem_rd_addr=0x10.
- len=7 INCR with rready toggling 1,0,0,1,... -> no beat lost or duplicated; payload stable while stalled; mem_rd_en never makes occupancy plus in-flight exceed 2.
- AR(addr=0x0010, size=2, len=1), ERR_CHECK_EN defined -> 2 beats SLVERR, rdata=0, no mem_rd_en; without the macro -> 2 OKAY beats reading words 1,2.
- AR(addr=0xFFF0, len=1, INCR), MEM_ADDR_W=8, ERR_CHECK_EN -> 2 DECERR beats; back-to-back AR id=1 then id=2 -> all id=1 beats precede all id=2 beats.
- Reset asserted mid-burst at beat 2 of 8 -> rvalid=0 immediately; after release, arready=1 and no stale beats appear.
